cdc_tx_arbiter: RTL and testbench

- Source-domain (clk_a) controller that shares one clock-domain-crossing channel among NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's word into a held data register.
- Sends the word with a 2-phase toggle handshake: xfer_req toggles out, xfer_ack toggles back.
- Resynchronizes the returning ack internally with a SYNC_STAGES flop chain. Sits between clk_a producers and the domain-B receive side.

---
 rtl/cdc_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: source-domain (clk_a) controller sharing one clock-domain crossing
// channel among NUM_REQ requesters. Round-robin arbitration picks a winner and
// captures its word into a held data register. The word is then sent with a
// 2-phase toggle handshake: xfer_req toggles out and xfer_ack toggles back.
// The returning ack is resynchronized through a SYNC_STAGES flop chain.
// Optional feature macro: ACK_TIMEOUT_EN. When it is defined, an ack timeout
// moves the block to a sticky ERR state and raises timeout_err.
module cdc_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk_a,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      xfer_req,
    output logic [DATA_W-1:0]         xfer_data,
    output logic [ID_W-1:0]           xfer_src,
    input  logic                      xfer_ack,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0]      xfer_data_q, xfer_data_d;
    logic [ID_W-1:0]        xfer_src_q, xfer_src_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic [DATA_W-1:0]      grant_word;
    logic [DATA_W-1:0]      req_word [NUM_REQ];
    int                     search_idx;

`ifdef ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
`else
    // The timeout length only matters when the timeout feature is built in.
    logic                   timeout_cyc_unused;
    assign timeout_cyc_unused = (TIMEOUT_CYC == 0);
`endif

    // Slice the flat payload bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_word
            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The last stage of the ack chain is the only view of xfer_ack in this domain.
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Shift the asynchronous ack toggle into the synchronizer chain.
    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack};
    end

    // Round-robin search: first valid requester at or above rr_ptr, with wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            search_idx = int'(rr_ptr_q) + k;
            if (search_idx >= NUM_REQ) begin
                search_idx = search_idx - NUM_REQ;
            end
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(search_idx);
            end
        end
    end

    assign grant_word = req_word[grant_idx];

    // Grant is combinational; it is only offered while the channel is idle.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Next-state logic for the handshake controller and its held outputs.
    always_comb begin
        state_d     = state_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        xfer_src_d  = xfer_src_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
`ifdef ACK_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    xfer_data_d = grant_word;
                    xfer_src_d  = ID_W'(grant_idx);
                    xfer_req_d  = ~xfer_req_q;
                    rr_ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT_ACK;
`ifdef ACK_TIMEOUT_EN
                    timeout_cnt_d = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                // The ack has come back once its synchronized level matches our toggle.
                if (ack_s == xfer_req_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef ACK_TIMEOUT_EN
                else begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                    if (timeout_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_ERR;
                    end
                end
`endif
            end
`ifdef ACK_TIMEOUT_EN
            ST_ERR: begin
                // Sticky until reset; the channel stays busy and the word stays held.
                busy_d = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding transfer.
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            xfer_src_q  <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            ack_sync_q  <= '0;
`ifdef ACK_TIMEOUT_EN
            timeout_cnt_q <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            xfer_src_q  <= xfer_src_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            ack_sync_q  <= ack_sync_d;
`ifdef ACK_TIMEOUT_EN
            timeout_cnt_q <= timeout_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign xfer_src  = xfer_src_q;
    assign busy      = busy_q;
`ifdef ACK_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Testbench for cdc_tx_arbiter: table-driven round-robin vectors plus hand-written
// sequences for holding while busy, a spurious ack, reset mid-transfer and a
// withheld ack. Inputs change on the falling edge and are checked just after it.
module tb_cdc_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int ID_W        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk_a;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      xfer_req;
    logic [DATA_W-1:0]         xfer_data;
    logic [ID_W-1:0]           xfer_src;
    logic                      xfer_ack;
    logic                      busy;
    logic                      timeout_err;

    int errors = 0;
    int checks = 0;
    logic exp_req = 1'b0;

    cdc_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_a      (clk_a),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_src   (xfer_src),
        .xfer_ack   (xfer_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk_a = 1'b0;
        forever #5 clk_a = ~clk_a;
    end

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] ready;
        logic [ID_W-1:0]    src;
        logic [DATA_W-1:0]  data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge while idle: offer valid, check grant, then check capture.
    task automatic do_grant(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] rdy,
                            input logic [ID_W-1:0] src, input logic [DATA_W-1:0] data);
        req_valid = v;
        #1;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        @(negedge clk_a);
        exp_req = ~exp_req;
        chk("xfer_req", 32'(xfer_req), 32'(exp_req));
        chk("xfer_src", 32'(xfer_src), 32'(src));
        chk("xfer_data", 32'(xfer_data), 32'(data));
        chk("busy_set", 32'(busy), 32'(1'b1));
        chk("ready_busy", 32'(req_ready), 32'(0));
        req_valid = '0;
        $display("grant valid=%b src=%0d data=%02h xfer_req=%0b", v, xfer_src, xfer_data, xfer_req);
    endtask

    // Domain-B model acks the outstanding toggle; busy falls SYNC_STAGES+1 edges later.
    task automatic do_ack();
        xfer_ack = exp_req;
        repeat (SYNC_STAGES) @(negedge clk_a);
        chk("busy_hold", 32'(busy), 32'(1'b1));
        @(negedge clk_a);
        chk("busy_fall", 32'(busy), 32'(1'b0));
        $display("ack toggle=%0b busy=%0b", xfer_ack, busy);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[1] = '{4'b1111, 4'b0010, 2'd1, 8'hB1};
        vecs[2] = '{4'b1111, 4'b0100, 2'd2, 8'hC2};
        vecs[3] = '{4'b1111, 4'b1000, 2'd3, 8'hD3};
        vecs[4] = '{4'b1111, 4'b0001, 2'd0, 8'hA5};
        vecs[5] = '{4'b1001, 4'b1000, 2'd3, 8'hD3};
        vecs[6] = '{4'b0110, 4'b0010, 2'd1, 8'hB1};
        vecs[7] = '{4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[8] = '{4'b1000, 4'b1000, 2'd3, 8'hD3};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
        xfer_ack  = 1'b0;

        // Reset state
        @(negedge clk_a);
        #1;
        chk("rst_xfer_req", 32'(xfer_req), 32'(0));
        chk("rst_xfer_data", 32'(xfer_data), 32'(0));
        chk("rst_xfer_src", 32'(xfer_src), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_timeout", 32'(timeout_err), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        @(negedge clk_a);
        rst = 1'b0;
        @(negedge clk_a);
        chk("idle_busy", 32'(busy), 32'(0));

        // Round-robin vectors, each acked by the domain-B model
        for (int i = 0; i < 9; i++) begin
            do_grant(vecs[i].valid, vecs[i].ready, vecs[i].src, vecs[i].data);
            do_ack();
        end

        // Requester 2 waits while requester 0 is outstanding
        do_grant(4'b0001, 4'b0001, 2'd0, 8'hA5);
        req_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_a);
            chk("hold_ready", 32'(req_ready), 32'(0));
            chk("hold_data", 32'(xfer_data), 32'(8'hA5));
            chk("hold_src", 32'(xfer_src), 32'(0));
        end
        do_ack();
        do_grant(4'b0100, 4'b0100, 2'd2, 8'hC2);
        do_ack();

        // Spurious ack toggle while idle
        xfer_ack = ~xfer_ack;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_a);
            chk("spur_busy", 32'(busy), 32'(0));
            chk("spur_req", 32'(xfer_req), 32'(exp_req));
            chk("spur_ready", 32'(req_ready), 32'(0));
        end
        $display("spurious ack busy=%0b xfer_req=%0b", busy, xfer_req);
        xfer_ack = exp_req;
        repeat (SYNC_STAGES + 2) @(negedge clk_a);
        do_grant(4'b0010, 4'b0010, 2'd1, 8'hB1);

        // Reset while waiting for ack; domain B resets in the same event
        @(negedge clk_a);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(xfer_req), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_data", 32'(xfer_data), 32'(0));
        xfer_ack  = 1'b0;
        exp_req   = 1'b0;
        req_valid = '0;
        $display("reset mid-transfer xfer_req=%0b busy=%0b", xfer_req, busy);
        @(negedge clk_a);
        rst = 1'b0;
        do_grant(4'b0010, 4'b0010, 2'd1, 8'hB1);
        do_ack();

        // Ack withheld
        do_grant(4'b0001, 4'b0001, 2'd0, 8'hA5);
`ifdef ACK_TIMEOUT_EN
        repeat (TIMEOUT_CYC - 1) @(negedge clk_a);
        chk("to_early", 32'(timeout_err), 32'(0));
        chk("to_early_busy", 32'(busy), 32'(1));
        @(negedge clk_a);
        chk("to_set", 32'(timeout_err), 32'(1));
        req_valid = 4'b0010;
        repeat (10) @(negedge clk_a);
        chk("to_sticky", 32'(timeout_err), 32'(1));
        chk("to_busy", 32'(busy), 32'(1));
        chk("to_ready", 32'(req_ready), 32'(0));
        chk("to_data", 32'(xfer_data), 32'(8'hA5));
`else
        req_valid = 4'b0010;
        repeat (40) @(negedge clk_a);
        chk("noto_err", 32'(timeout_err), 32'(0));
        chk("noto_busy", 32'(busy), 32'(1));
        chk("noto_ready", 32'(req_ready), 32'(0));
        chk("noto_data", 32'(xfer_data), 32'(8'hA5));
`endif
        $display("ack withheld busy=%0b timeout_err=%0b", busy, timeout_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
